// File: rtl/adder_share_sched.sv
// adder_share_sched: round-robin scheduler sharing one 8-bit adder
// among NREQ requesters, one operand byte per cycle, LSB first.
module adder_share_sched #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 2,
  parameter int IDW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8*NBYTES-1:0] req_a,
  input  logic [NREQ*8*NBYTES-1:0] req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [8*NBYTES-1:0]  rsp_sum,
  output logic                 rsp_cout,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout,
  output logic                 busy
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic [KW-1:0]  k;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           cin_q;
  logic           carry_q;
  logic           cout_q;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] ptr_nx;
  logic [W-1:0]   gnt_a;
  logic [W-1:0]   gnt_b;
  logic           gnt_c;
  logic           last;

  // Two passes: indices at/above the pointer win, then wrap to 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i] && (IDW'(i) >= ptr)) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && req_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    gnt_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        gnt_a = req_a[i*W +: W];
        gnt_b = req_b[i*W +: W];
        gnt_c = req_cin[i];
      end
    end
  end

  assign ptr_nx = (gnt_id == IDW'(NREQ - 1))
                ? '0 : gnt_id + IDW'(1);
  assign last   = (k == KW'(NBYTES - 1));

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_vld && rst_n) begin
          req_ready = NREQ'(1) << gnt_id;
          state_nx  = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[int'(k)*8 +: 8];
        add_b   = b_q[int'(k)*8 +: 8];
        add_cin = (k == '0) ? cin_q : carry_q;
        if (last) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      id_q    <= '0;
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            a_q   <= gnt_a;
            b_q   <= gnt_b;
            cin_q <= gnt_c;
            id_q  <= gnt_id;
            ptr   <= ptr_nx;
            k     <= '0;
          end
        end
        RUN: begin
          sum_q[int'(k)*8 +: 8] <= add_sum;
          carry_q <= add_cout;
          k       <= k + KW'(1);
          if (last) begin
            cout_q <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign busy     = (state != IDLE);

endmodule
